// File: rtl/step_profile_pkg.sv
// Shared types and default sizing for the stepper command/profile stage.
package step_profile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int DEF_CNT_W          = 16;
  localparam int DEF_POS_W          = 24;
  localparam int DEF_IVL_W          = 20;
  localparam int DEF_START_INTERVAL = 400000;
  localparam int DEF_MIN_INTERVAL   = 200000;
  localparam int DEF_ACCEL_DEC      = 20000;
  localparam int DEF_DIR_SETUP      = 1000;
  localparam int DEF_HOLD_CYCLES    = 100000;

  // Largest of three cycle counts; sizes the shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/step_profile_gen_if.sv
// Host-side command channel: move request handshake plus level abort.
interface step_profile_gen_if
  import step_profile_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_count,
    output abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_count,
    input  abort,
    output cmd_ready
  );

endinterface

// File: rtl/step_ramp_calc.sv
// Next pulse interval and ramp depth after a step, clamped to the
// [MIN_INTERVAL, START_INTERVAL] window; purely combinational.
module step_ramp_calc
  import step_profile_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int IVL_W          = DEF_IVL_W,
  parameter int START_INTERVAL = DEF_START_INTERVAL,
  parameter int MIN_INTERVAL   = DEF_MIN_INTERVAL,
  parameter int ACCEL_DEC      = DEF_ACCEL_DEC
) (
  input  logic [IVL_W-1:0] i_ivl,
  input  logic [CNT_W-1:0] i_ramp,
  input  logic [CNT_W-1:0] i_rem_new,
  output logic [IVL_W-1:0] o_ivl,
  output logic [CNT_W-1:0] o_ramp
);

  // One extra bit so the upward step can never wrap before clamping.
  localparam int XW = IVL_W + 1;
  localparam logic [XW-1:0] LP_START = XW'(START_INTERVAL);
  localparam logic [XW-1:0] LP_MIN   = XW'(MIN_INTERVAL);
  localparam logic [XW-1:0] LP_STEP  = XW'(ACCEL_DEC);
  localparam logic [XW-1:0] LP_FLOOR = LP_MIN + LP_STEP;

  logic [XW-1:0] w_ivl_x;
  logic [XW-1:0] w_ivl_up;

  assign w_ivl_x  = {1'b0, i_ivl};
  assign w_ivl_up = w_ivl_x + LP_STEP;

  // Decelerate once the remaining steps fit in the ramp built so far.
  always_comb begin
    o_ivl  = i_ivl;
    o_ramp = i_ramp;
    if (i_rem_new <= i_ramp) begin
      if (w_ivl_up > LP_START) begin
        o_ivl = LP_START[IVL_W-1:0];
      end else begin
        o_ivl = w_ivl_up[IVL_W-1:0];
      end
      if (i_ramp != {CNT_W{1'b0}}) begin
        o_ramp = i_ramp - CNT_W'(1);
      end else begin
        o_ramp = {CNT_W{1'b0}};
      end
    end else if (w_ivl_x > LP_MIN) begin
      if (w_ivl_x >= LP_FLOOR) begin
        o_ivl = i_ivl - LP_STEP[IVL_W-1:0];
      end else begin
        o_ivl = LP_MIN[IVL_W-1:0];
      end
      if (i_ramp != {CNT_W{1'b1}}) begin
        o_ramp = i_ramp + CNT_W'(1);
      end else begin
        o_ramp = i_ramp;
      end
    end else begin
      o_ivl  = i_ivl;
      o_ramp = i_ramp;
    end
  end

endmodule

// File: rtl/step_profile_gen.sv
// Move command stage: turns (dir, count) into a trapezoidal StepEnable
// train for the motor drive and tracks absolute signed position.
module step_profile_gen
  import step_profile_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int POS_W          = DEF_POS_W,
  parameter int IVL_W          = DEF_IVL_W,
  parameter int START_INTERVAL = DEF_START_INTERVAL,
  parameter int MIN_INTERVAL   = DEF_MIN_INTERVAL,
  parameter int ACCEL_DEC      = DEF_ACCEL_DEC,
  parameter int DIR_SETUP      = DEF_DIR_SETUP,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES
) (
  input  logic              Clock,
  input  logic              Reset,
  step_profile_gen_if.slave cmd_if,
  output logic              StepEnable,
  output logic              Direction,
  output logic              ProvideStaticHolding,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [POS_W-1:0]  position
);

  localparam int TMR_W = $clog2(max3(START_INTERVAL, DIR_SETUP, HOLD_CYCLES) + 1);
  localparam logic [TMR_W-1:0] LP_TMR_ONE = TMR_W'(1);
  localparam logic [TMR_W-1:0] LP_SETUP   = TMR_W'(DIR_SETUP);
  localparam logic [TMR_W-1:0] LP_HOLD    = TMR_W'(HOLD_CYCLES);
  localparam logic [IVL_W-1:0] LP_START   = IVL_W'(START_INTERVAL);

  state_e           r_state;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_ramp;
  logic [IVL_W-1:0] r_ivl;
  logic             r_cmd_ready;
  logic             r_end_pend;
  logic             r_end_abort;

  logic [CNT_W-1:0] w_rem_new;
  logic [CNT_W-1:0] w_ramp_next;
  logic [IVL_W-1:0] w_ivl_next;

  assign w_rem_new        = r_rem - CNT_W'(1);
  assign cmd_if.cmd_ready = r_cmd_ready;

  step_ramp_calc #(
    .CNT_W          (CNT_W),
    .IVL_W          (IVL_W),
    .START_INTERVAL (START_INTERVAL),
    .MIN_INTERVAL   (MIN_INTERVAL),
    .ACCEL_DEC      (ACCEL_DEC)
  ) u_ramp (
    .i_ivl     (r_ivl),
    .i_ramp    (r_ramp),
    .i_rem_new (w_rem_new),
    .o_ivl     (w_ivl_next),
    .o_ramp    (w_ramp_next)
  );

  // Move FSM; r_end_pend delays done/aborted by one cycle after the move ends.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state              <= ST_IDLE;
      r_timer              <= {TMR_W{1'b0}};
      r_rem                <= {CNT_W{1'b0}};
      r_ramp               <= {CNT_W{1'b0}};
      r_ivl                <= LP_START;
      r_cmd_ready          <= 1'b1;
      r_end_pend           <= 1'b0;
      r_end_abort          <= 1'b0;
      StepEnable           <= 1'b0;
      Direction            <= 1'b0;
      ProvideStaticHolding <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      aborted              <= 1'b0;
      position             <= {POS_W{1'b0}};
    end else begin
      StepEnable  <= 1'b0;
      done        <= r_end_pend;
      aborted     <= r_end_pend & r_end_abort;
      r_end_pend  <= 1'b0;
      r_end_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_if.cmd_valid && r_cmd_ready) begin
            Direction            <= cmd_if.cmd_dir;
            r_rem                <= cmd_if.cmd_count;
            r_ivl                <= LP_START;
            r_ramp               <= {CNT_W{1'b0}};
            ProvideStaticHolding <= 1'b1;
            busy                 <= 1'b1;
            r_cmd_ready          <= 1'b0;
            if (cmd_if.cmd_count == {CNT_W{1'b0}}) begin
              r_state    <= ST_HOLD;
              r_timer    <= LP_HOLD;
              r_end_pend <= 1'b1;
            end else begin
              r_state <= ST_SETUP;
              r_timer <= LP_SETUP;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP, ST_RUN: begin
          if (cmd_if.abort) begin
            r_state     <= ST_HOLD;
            r_timer     <= LP_HOLD;
            r_end_pend  <= 1'b1;
            r_end_abort <= 1'b1;
          end else if (r_timer == LP_TMR_ONE) begin
            // Pulse cycle: the gap to the next pulse uses the pre-update interval.
            StepEnable <= 1'b1;
            r_rem      <= w_rem_new;
            r_ivl      <= w_ivl_next;
            r_ramp     <= w_ramp_next;
            position   <= Direction ? (position + POS_W'(1)) : (position - POS_W'(1));
            if (w_rem_new == {CNT_W{1'b0}}) begin
              r_state    <= ST_HOLD;
              r_timer    <= LP_HOLD;
              r_end_pend <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_timer <= TMR_W'(r_ivl);
            end
          end else begin
            r_timer <= r_timer - LP_TMR_ONE;
          end
        end
        ST_HOLD: begin
          if (r_timer == LP_TMR_ONE) begin
            r_state              <= ST_IDLE;
            ProvideStaticHolding <= 1'b0;
            busy                 <= 1'b0;
            r_cmd_ready          <= 1'b1;
          end else begin
            r_timer <= r_timer - LP_TMR_ONE;
          end
        end
        default: begin
          r_state              <= ST_IDLE;
          ProvideStaticHolding <= 1'b0;
          busy                 <= 1'b0;
          r_cmd_ready          <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_profile_gen.sv
// Randomized bench for step_profile_gen against a pulse-schedule model;
// a second narrow-position instance shares the stimulus to exercise wrap.
module tb_step_profile_gen;
  import step_profile_pkg::*;

  localparam int T_START = 10;
  localparam int T_MIN   = 4;
  localparam int T_AD    = 2;
  localparam int T_SETUP = 3;
  localparam int T_HOLD  = 5;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  step_profile_gen_if #(.CNT_W(16)) if_a ();
  step_profile_gen_if #(.CNT_W(16)) if_b ();

  logic        se_a, dir_a, psh_a, busy_a, done_a, ab_a;
  logic [23:0] pos_a;
  logic        se_b, dir_b, psh_b, busy_b, done_b, ab_b;
  logic [3:0]  pos_b;

  step_profile_gen #(
    .CNT_W(16), .POS_W(24), .IVL_W(20), .START_INTERVAL(T_START), .MIN_INTERVAL(T_MIN),
    .ACCEL_DEC(T_AD), .DIR_SETUP(T_SETUP), .HOLD_CYCLES(T_HOLD)
  ) dut_a (
    .Clock(Clock), .Reset(Reset), .cmd_if(if_a), .StepEnable(se_a), .Direction(dir_a),
    .ProvideStaticHolding(psh_a), .busy(busy_a), .done(done_a), .aborted(ab_a), .position(pos_a)
  );

  step_profile_gen #(
    .CNT_W(16), .POS_W(4), .IVL_W(20), .START_INTERVAL(T_START), .MIN_INTERVAL(T_MIN),
    .ACCEL_DEC(T_AD), .DIR_SETUP(T_SETUP), .HOLD_CYCLES(T_HOLD)
  ) dut_b (
    .Clock(Clock), .Reset(Reset), .cmd_if(if_b), .StepEnable(se_b), .Direction(dir_b),
    .ProvideStaticHolding(psh_b), .busy(busy_b), .done(done_b), .aborted(ab_b), .position(pos_b)
  );

  int n_total = 0;
  int n_bad   = 0;
  int exp_pulses[$];
  int obs_pulses[$];
  int exp_end;
  bit exp_ab;
  int model_pos = 0;
  int obs_done_off;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic set_cmd(input bit v, input bit d, input int c, input bit ab);
    if_a.cmd_valid = v; if_a.cmd_dir = d; if_a.cmd_count = 16'(c); if_a.abort = ab;
    if_b.cmd_valid = v; if_b.cmd_dir = d; if_b.cmd_count = 16'(c); if_b.abort = ab;
  endtask

  // Pulse offsets from the accept edge, derived from the profile rules.
  task automatic model_move(input int count, input int abort_at);
    int t, ivl, ramp, rem, nt;
    exp_pulses.delete();
    exp_ab = 1'b0;
    t = T_SETUP; ivl = T_START; ramp = 0; rem = count;
    if (count == 0) begin
      exp_end = 0;
    end else begin
      while (1) begin
        if (abort_at != 0 && abort_at <= t) begin
          exp_end = abort_at; exp_ab = 1'b1; break;
        end
        exp_pulses.push_back(t);
        rem--;
        if (rem == 0) begin exp_end = t; break; end
        nt = t + ivl;
        if (rem <= ramp) begin
          ivl  = (ivl + T_AD > T_START) ? T_START : ivl + T_AD;
          ramp = (ramp > 0) ? ramp - 1 : 0;
        end else if (ivl > T_MIN) begin
          ivl  = (ivl - T_AD < T_MIN) ? T_MIN : ivl - T_AD;
          ramp = ramp + 1;
        end
        t = nt;
      end
    end
  endtask

  task automatic run_move(input bit dir, input int count, input int abort_at, input bit hold_valid);
    int done_cnt, idle_off, psh_fall, limit, n;
    bit ab_seen, b2b, prev_se;
    model_move(count, abort_at);
    set_cmd(1'b1, dir, count, 1'b0);
    @(posedge Clock); @(negedge Clock);
    chk_eq("accept_busy", 32'(busy_a), 32'd1);
    chk_eq("accept_ready", 32'(if_a.cmd_ready), 32'd0);
    chk_eq("accept_dir", 32'(dir_a), 32'(dir));
    chk_eq("accept_hold", 32'(psh_a), 32'd1);
    if (!hold_valid) set_cmd(1'b0, dir, count, 1'b0);
    obs_pulses.delete();
    done_cnt = 0; obs_done_off = -1; idle_off = -1; psh_fall = -1;
    ab_seen = 1'b0; b2b = 1'b0; prev_se = 1'b0;
    limit = exp_end + T_HOLD + 4;
    for (int k = 1; k <= limit; k++) begin
      if_a.abort = (k == abort_at); if_b.abort = (k == abort_at);
      @(posedge Clock); @(negedge Clock);
      if (se_a) obs_pulses.push_back(k);
      if (se_a && prev_se) b2b = 1'b1;
      prev_se = se_a;
      if (done_a) begin done_cnt++; obs_done_off = k; ab_seen = ab_a; end
      if (psh_fall < 0 && !psh_a) psh_fall = k;
      if (if_a.cmd_ready) begin
        idle_off = k;
        chk_eq("idle_busy", 32'(busy_a), 32'd0);
        break;
      end
    end
    set_cmd(1'b0, dir, count, 1'b0);
    chk_eq("pulse_count", 32'(obs_pulses.size()), 32'(exp_pulses.size()));
    n = (obs_pulses.size() < exp_pulses.size()) ? obs_pulses.size() : exp_pulses.size();
    for (int i = 0; i < n; i++) chk_eq("pulse_time", 32'(obs_pulses[i]), 32'(exp_pulses[i]));
    chk_eq("no_back_to_back", 32'(b2b), 32'd0);
    chk_eq("done_time", 32'(obs_done_off), 32'(exp_end + 1));
    chk_eq("done_once", 32'(done_cnt), 32'd1);
    chk_eq("aborted_flag", 32'(ab_seen), 32'(exp_ab));
    chk_eq("hold_fall", 32'(psh_fall), 32'(exp_end + T_HOLD));
    chk_eq("ready_return", 32'(idle_off), 32'(exp_end + T_HOLD));
    model_pos = model_pos + (dir ? exp_pulses.size() : -exp_pulses.size());
    chk_eq("position", 32'($signed(pos_a)), 32'(model_pos));
    chk_eq("position_wrap4", 32'(pos_b), 32'(model_pos & 15));
  endtask

  initial begin
    int t1_exp[6];
    int rdir, rcnt, rab;
    t1_exp = '{3, 13, 21, 27, 31, 37};
    set_cmd(1'b0, 1'b0, 0, 1'b0);
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk_eq("rst_step", 32'(se_a), 32'd0);
    chk_eq("rst_dir", 32'(dir_a), 32'd0);
    chk_eq("rst_hold", 32'(psh_a), 32'd0);
    chk_eq("rst_busy", 32'(busy_a), 32'd0);
    chk_eq("rst_done", 32'(done_a), 32'd0);
    chk_eq("rst_pos", 32'(pos_a), 32'd0);
    chk_eq("rst_ready", 32'(if_a.cmd_ready), 32'd1);
    Reset = 1'b0;

    // Basic trapezoid against hand-derived edge offsets.
    run_move(1'b1, 6, 0, 1'b0);
    for (int i = 0; i < 6; i++)
      if (i < obs_pulses.size()) chk_eq("t1_pulse", 32'(obs_pulses[i]), 32'(t1_exp[i]));
    chk_eq("t1_done", 32'(obs_done_off), 32'd38);
    chk_eq("t1_pos", 32'($signed(pos_a)), 32'd6);

    run_move(1'b0, 20, 0, 1'b0);
    chk_eq("t2_pos", 32'($signed(pos_a)), -32'sd14);

    run_move(1'b1, 0, 0, 1'b0);
    chk_eq("t3_done", 32'(obs_done_off), 32'd1);

    // Abort on the third scheduled pulse edge.
    run_move(1'b1, 6, 21, 1'b0);
    chk_eq("t4_pulses", 32'(obs_pulses.size()), 32'd2);
    chk_eq("t4_pos", 32'($signed(pos_a)), -32'sd12);

    // Reset mid-run, then an immediate new command.
    set_cmd(1'b1, 1'b1, 6, 1'b0);
    @(posedge Clock); @(negedge Clock);
    set_cmd(1'b0, 1'b1, 6, 1'b0);
    repeat (14) @(negedge Clock);
    chk_eq("t5_busy_before", 32'(busy_a), 32'd1);
    Reset = 1'b1;
    @(posedge Clock); @(negedge Clock);
    chk_eq("t5_step", 32'(se_a), 32'd0);
    chk_eq("t5_dir", 32'(dir_a), 32'd0);
    chk_eq("t5_hold", 32'(psh_a), 32'd0);
    chk_eq("t5_busy", 32'(busy_a), 32'd0);
    chk_eq("t5_done", 32'(done_a), 32'd0);
    chk_eq("t5_aborted", 32'(ab_a), 32'd0);
    chk_eq("t5_pos", 32'(pos_a), 32'd0);
    chk_eq("t5_ready", 32'(if_a.cmd_ready), 32'd1);
    Reset = 1'b0;
    model_pos = 0;
    run_move(1'b1, 0, 0, 1'b0);

    // cmd_valid held through the move; narrow position wraps 15 -> -1.
    run_move(1'b1, 7, 0, 1'b1);
    run_move(1'b1, 8, 0, 1'b1);
    chk_eq("t6_wrap", 32'($signed(pos_b)), -32'sd1);
    chk_eq("t6_pos", 32'(pos_a), 32'd15);

    for (int r = 0; r < 12; r++) begin
      rdir = $urandom_range(0, 1);
      rcnt = $urandom_range(0, 14);
      rab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : 0;
      run_move(rdir[0], rcnt, rab, rdir[0] & (rcnt > 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
